// File: rtl/instruction_fetcher_pkg.sv
// Shared encodings for the per-SIMD instruction fetch stage.
//   SIMD_*  : SIMD control-state encodings presented on simd_state_i
//   fetch_state_t : fetcher FSM state, exported on fetcher_state_o
package instruction_fetcher_pkg;

    localparam logic [2:0] SIMD_IDLE    = 3'd0;
    localparam logic [2:0] SIMD_FETCH   = 3'd1;
    localparam logic [2:0] SIMD_DECODE  = 3'd2;
    localparam logic [2:0] SIMD_EXECUTE = 3'd3;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: fetch stage sitting behind the SIMD PC register.
// While the SIMD unit is in SIMD_FETCH, reads one instruction word from
// program memory over a valid/ready port, holds it on instruction_out_o and
// raises fetch_done_o until the SIMD unit moves to SIMD_DECODE.
//
// Optional build macro: FETCH_LAST_HIT_EN
//   Adds a single-entry {tag_valid, last_addr} register. A fetch of the same
//   in-range address as the last completed memory fetch finishes in one cycle
//   without touching memory.
//
// Ports
//   clk_i               clock, all state on posedge
//   rst_i               synchronous active-high reset
//   enable_i            0 = hold all state and outputs
//   simd_state_i        SIMD control state (SIMD_* encodings)
//   dispatch_new_wave_i aborts any fetch, returns to FETCH_IDLE
//   pc_i                current wave PC
//   mem_read_valid_o    read request to program memory
//   mem_read_address_o  read address (pc low bits)
//   mem_read_ready_i    memory response, data valid same cycle
//   mem_read_data_i     instruction word from memory
//   fetcher_state_o     current FSM state
//   fetch_done_o        instruction_out_o valid for current pc
//   instruction_out_o   latched instruction word
//   fetch_oob_o         last fetch had pc beyond program memory
//
// state      | meaning
// FETCH_IDLE | waiting for SIMD_FETCH
// FETCH_REQ  | request outstanding, waiting for mem_read_ready_i
// FETCH_DONE | instruction held, waiting for SIMD_DECODE
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
    parameter int PROGRAM_MEM_ADDR_BITS  = 8,
    parameter int PROGRAM_MEM_DATA_WIDTH = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic [2:0]                        simd_state_i,
    input  logic                              dispatch_new_wave_i,
    input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_i,
    output logic                              mem_read_valid_o,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]  mem_read_address_o,
    input  logic                              mem_read_ready_i,
    input  logic [PROGRAM_MEM_DATA_WIDTH-1:0] mem_read_data_i,
    output logic [1:0]                        fetcher_state_o,
    output logic                              fetch_done_o,
    output logic [PROGRAM_MEM_DATA_WIDTH-1:0] instruction_out_o,
    output logic                              fetch_oob_o
);

    fetch_state_t                      state_q, state_d;
    logic                              valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]  addr_q, addr_d;
    logic                              done_q, done_d;
    logic [PROGRAM_MEM_DATA_WIDTH-1:0] instr_q, instr_d;
    logic                              oob_q, oob_d;

    logic                              in_range;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]  pc_lo;
    logic                              tag_hit;

    assign pc_lo    = pc_i[PROGRAM_MEM_ADDR_BITS-1:0];
    assign in_range = (pc_i >> PROGRAM_MEM_ADDR_BITS) == '0;

`ifdef FETCH_LAST_HIT_EN
    logic                              tag_valid_q, tag_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]  last_addr_q, last_addr_d;

    assign tag_hit = tag_valid_q && (last_addr_q == pc_lo);
`else
    assign tag_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        done_d  = done_q;
        instr_d = instr_q;
        oob_d   = oob_q;
`ifdef FETCH_LAST_HIT_EN
        tag_valid_d = tag_valid_q;
        last_addr_d = last_addr_q;
`endif
        if (enable_i) begin
            if (dispatch_new_wave_i) begin
                // Any concurrent memory response is dropped on the floor.
                state_d = FETCH_IDLE;
                valid_d = 1'b0;
                done_d  = 1'b0;
`ifdef FETCH_LAST_HIT_EN
                tag_valid_d = 1'b0;
`endif
            end else begin
                unique case (state_q)
                    FETCH_IDLE: begin
                        if (simd_state_i == SIMD_FETCH) begin
                            if (!in_range) begin
                                state_d = FETCH_DONE;
                                instr_d = '0;
                                oob_d   = 1'b1;
                                done_d  = 1'b1;
`ifdef FETCH_LAST_HIT_EN
                                // instruction_out now holds the NOP, so it
                                // no longer matches last_addr's word.
                                tag_valid_d = 1'b0;
`endif
                            end else if (tag_hit) begin
                                state_d = FETCH_DONE;
                                oob_d   = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = FETCH_REQ;
                                valid_d = 1'b1;
                                addr_d  = pc_lo;
                                oob_d   = 1'b0;
                            end
                        end
                    end
                    FETCH_REQ: begin
                        if (mem_read_ready_i) begin
                            state_d = FETCH_DONE;
                            instr_d = mem_read_data_i;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
`ifdef FETCH_LAST_HIT_EN
                            tag_valid_d = 1'b1;
                            last_addr_d = addr_q;
`endif
                        end
                    end
                    FETCH_DONE: begin
                        if (simd_state_i == SIMD_DECODE) begin
                            state_d = FETCH_IDLE;
                            done_d  = 1'b0;
                        end
                    end
                    default: begin
                        state_d = FETCH_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            instr_q <= '0;
            oob_q   <= 1'b0;
`ifdef FETCH_LAST_HIT_EN
            tag_valid_q <= 1'b0;
            last_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            instr_q <= instr_d;
            oob_q   <= oob_d;
`ifdef FETCH_LAST_HIT_EN
            tag_valid_q <= tag_valid_d;
            last_addr_q <= last_addr_d;
`endif
        end
    end

    assign mem_read_valid_o   = valid_q;
    assign mem_read_address_o = addr_q;
    assign fetcher_state_o    = state_q;
    assign fetch_done_o       = done_q;
    assign instruction_out_o  = instr_q;
    assign fetch_oob_o        = oob_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher. Directed table of fetches,
// hand-written corner sequences, then randomized fetches against a
// transaction-level model (memory array + last-instruction / last-tag).
module tb_instruction_fetcher;
    import instruction_fetcher_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [2:0]  simd_state_i;
    logic        dispatch_new_wave_i;
    logic [31:0] pc_i;
    logic        mem_read_valid_o;
    logic [7:0]  mem_read_address_o;
    logic        mem_read_ready_i;
    logic [15:0] mem_read_data_i;
    logic [1:0]  fetcher_state_o;
    logic        fetch_done_o;
    logic [15:0] instruction_out_o;
    logic        fetch_oob_o;

    always #5 clk_i = ~clk_i;

    instruction_fetcher dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .enable_i            (enable_i),
        .simd_state_i        (simd_state_i),
        .dispatch_new_wave_i (dispatch_new_wave_i),
        .pc_i                (pc_i),
        .mem_read_valid_o    (mem_read_valid_o),
        .mem_read_address_o  (mem_read_address_o),
        .mem_read_ready_i    (mem_read_ready_i),
        .mem_read_data_i     (mem_read_data_i),
        .fetcher_state_o     (fetcher_state_o),
        .fetch_done_o        (fetch_done_o),
        .instruction_out_o   (instruction_out_o),
        .fetch_oob_o         (fetch_oob_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [15:0] mem_m [256];
    logic [15:0] instr_m;
    logic        oob_m;
    bit          tag_valid_m;
    logic [31:0] tag_pc_m;
    int          vcnt;

    typedef struct {
        logic [31:0] pc;
        int          delay;
        int          gap;
        bit          abort;
        logic [15:0] data;
        logic [15:0] exp_instr;
        logic        exp_oob;
        int          exp_vcnt;
    } vec_t;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit hit_expected(input logic [31:0] pc);
        bit h;
        h = tag_valid_m && (pc < 32'd256) && (pc == tag_pc_m);
`ifdef FETCH_LAST_HIT_EN
        return h;
`else
        return h & 1'b0;
`endif
    endfunction

    // One fetch: SIMD_FETCH for one edge, optional enable-low gap, memory
    // response after `delay` wait cycles, optional abort by new wave.
    task automatic fetch(input logic [31:0] pc, input int delay, input int gap, input bit abort);
        bit oob;
        bit hit;
        logic [7:0] a;
        oob = (pc >= 32'd256);
        hit = hit_expected(pc);
        a = pc[7:0];
        vcnt = 0;
        simd_state_i = SIMD_FETCH;
        pc_i = pc;
        step();
        simd_state_i = SIMD_EXECUTE;
        if (oob) begin
            instr_m = '0; oob_m = 1'b1; tag_valid_m = 1'b0;
            chk("oob_valid", mem_read_valid_o, 0);
            chk("oob_done", fetch_done_o, 1);
            chk("oob_instr", instruction_out_o, 0);
            chk("oob_flag", fetch_oob_o, 1);
            chk("oob_state", fetcher_state_o, FETCH_DONE);
        end else if (hit) begin
            oob_m = 1'b0;
            chk("hit_valid", mem_read_valid_o, 0);
            chk("hit_done", fetch_done_o, 1);
            chk("hit_instr", instruction_out_o, instr_m);
            chk("hit_state", fetcher_state_o, FETCH_DONE);
        end else begin
            oob_m = 1'b0;
            if (mem_read_valid_o) vcnt++;
            chk("req_valid", mem_read_valid_o, 1);
            chk("req_addr", mem_read_address_o, a);
            chk("req_done", fetch_done_o, 0);
            chk("req_oob", fetch_oob_o, 0);
            chk("req_state", fetcher_state_o, FETCH_REQ);
            for (int g = 0; g < gap; g++) begin
                enable_i = 1'b0;
                mem_read_ready_i = 1'($urandom);
                mem_read_data_i = 16'($urandom);
                simd_state_i = 3'($urandom_range(0, 3));
                step();
                if (mem_read_valid_o) vcnt++;
                chk("gap_state", fetcher_state_o, FETCH_REQ);
                chk("gap_valid", mem_read_valid_o, 1);
                chk("gap_addr", mem_read_address_o, a);
                chk("gap_done", fetch_done_o, 0);
            end
            enable_i = 1'b1;
            mem_read_ready_i = 1'b0;
            simd_state_i = SIMD_EXECUTE;
            for (int i = 0; i < delay; i++) begin
                step();
                if (mem_read_valid_o) vcnt++;
                chk("wait_valid", mem_read_valid_o, 1);
                chk("wait_addr", mem_read_address_o, a);
                chk("wait_done", fetch_done_o, 0);
            end
            if (abort) begin
                dispatch_new_wave_i = 1'b1;
                mem_read_ready_i = 1'b1;
                mem_read_data_i = ~mem_m[a];
                step();
                dispatch_new_wave_i = 1'b0;
                mem_read_ready_i = 1'b0;
                tag_valid_m = 1'b0;
                chk("abort_state", fetcher_state_o, FETCH_IDLE);
                chk("abort_valid", mem_read_valid_o, 0);
                chk("abort_done", fetch_done_o, 0);
                chk("abort_instr", instruction_out_o, instr_m);
                return;
            end
            mem_read_ready_i = 1'b1;
            mem_read_data_i = mem_m[a];
            step();
            mem_read_ready_i = 1'b0;
            mem_read_data_i = 16'($urandom);
            instr_m = mem_m[a];
            tag_valid_m = 1'b1;
            tag_pc_m = pc;
            chk("resp_valid", mem_read_valid_o, 0);
            chk("resp_done", fetch_done_o, 1);
            chk("resp_instr", instruction_out_o, instr_m);
            chk("resp_state", fetcher_state_o, FETCH_DONE);
        end
        // Not yet decoding: result must stay presented.
        step();
        chk("hold_done", fetch_done_o, 1);
        chk("hold_state", fetcher_state_o, FETCH_DONE);
        simd_state_i = SIMD_DECODE;
        step();
        simd_state_i = SIMD_EXECUTE;
        chk("dec_state", fetcher_state_o, FETCH_IDLE);
        chk("dec_done", fetch_done_o, 0);
        chk("dec_instr", instruction_out_o, instr_m);
        chk("dec_oob", fetch_oob_o, oob_m);
    endtask

    task automatic pulse_dispatch();
        dispatch_new_wave_i = 1'b1;
        step();
        dispatch_new_wave_i = 1'b0;
        tag_valid_m = 1'b0;
        chk("nw_state", fetcher_state_o, FETCH_IDLE);
        chk("nw_valid", mem_read_valid_o, 0);
        chk("nw_done", fetch_done_o, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        instr_m = '0; oob_m = 1'b0; tag_valid_m = 1'b0; tag_pc_m = '0;
        chk("rst_state", fetcher_state_o, FETCH_IDLE);
        chk("rst_valid", mem_read_valid_o, 0);
        chk("rst_addr", mem_read_address_o, 0);
        chk("rst_done", fetch_done_o, 0);
        chk("rst_instr", instruction_out_o, 0);
        chk("rst_oob", fetch_oob_o, 0);
    endtask

    vec_t vecs[10];

    initial begin
        rst_i = 1'b1;
        enable_i = 1'b1;
        simd_state_i = SIMD_IDLE;
        dispatch_new_wave_i = 1'b0;
        pc_i = '0;
        mem_read_ready_i = 1'b0;
        mem_read_data_i = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = 16'($urandom);

        vecs[0] = '{32'd3,         0, 0, 1'b0, 16'hA1B2, 16'hA1B2, 1'b0, 1};
        vecs[1] = '{32'd5,         4, 0, 1'b0, 16'h1234, 16'h1234, 1'b0, 5};
        vecs[2] = '{32'h100,       0, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0};
        vecs[3] = '{32'd11,        2, 0, 1'b1, 16'h7777, 16'h0000, 1'b0, 3};
        vecs[4] = '{32'd9,         2, 3, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 6};
        vecs[5] = '{32'd255,       1, 0, 1'b0, 16'h5A5A, 16'h5A5A, 1'b0, 2};
        vecs[6] = '{32'hFFFF_FFFF, 0, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0};
        vecs[7] = '{32'd0,         0, 0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0, 1};
        vecs[8] = '{32'h200,       0, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0};
        vecs[9] = '{32'd128,       3, 0, 1'b0, 16'hC3C3, 16'hC3C3, 1'b0, 4};

        do_reset();

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].pc < 32'd256) mem_m[vecs[v].pc[7:0]] = vecs[v].data;
            fetch(vecs[v].pc, vecs[v].delay, vecs[v].gap, vecs[v].abort);
            chk($sformatf("tbl%0d_instr", v), instruction_out_o, vecs[v].exp_instr);
            chk($sformatf("tbl%0d_oob", v), fetch_oob_o, vecs[v].exp_oob);
            chk($sformatf("tbl%0d_vcnt", v), vcnt, vecs[v].exp_vcnt);
        end

        // Repeat fetch of the same pc: hit path only with the tag register.
        mem_m[7] = 16'h7007;
        fetch(32'd7, 1, 0, 1'b0);
        chk("rep_first_vcnt", vcnt, 2);
        fetch(32'd7, 1, 0, 1'b0);
`ifdef FETCH_LAST_HIT_EN
        chk("rep_second_vcnt", vcnt, 0);
`else
        chk("rep_second_vcnt", vcnt, 2);
`endif
        chk("rep_instr", instruction_out_o, 16'h7007);
        pulse_dispatch();
        fetch(32'd7, 1, 0, 1'b0);
        chk("rep_after_nw_vcnt", vcnt, 2);

        // Ready while idle is ignored.
        mem_read_ready_i = 1'b1;
        mem_read_data_i = 16'hDEAD;
        step();
        step();
        mem_read_ready_i = 1'b0;
        chk("idle_ready_state", fetcher_state_o, FETCH_IDLE);
        chk("idle_ready_instr", instruction_out_o, instr_m);
        chk("idle_ready_done", fetch_done_o, 0);

        // enable=0 holds even a SIMD_FETCH in idle.
        enable_i = 1'b0;
        simd_state_i = SIMD_FETCH;
        pc_i = 32'd40;
        step();
        chk("en0_idle_state", fetcher_state_o, FETCH_IDLE);
        chk("en0_idle_valid", mem_read_valid_o, 0);
        enable_i = 1'b1;
        simd_state_i = SIMD_EXECUTE;

        // Reset wins mid-request, even with enable low and ready high.
        simd_state_i = SIMD_FETCH;
        pc_i = 32'd20;
        step();
        simd_state_i = SIMD_EXECUTE;
        chk("mid_req_state", fetcher_state_o, FETCH_REQ);
        enable_i = 1'b0;
        mem_read_ready_i = 1'b1;
        mem_read_data_i = 16'hFACE;
        do_reset();
        enable_i = 1'b1;
        mem_read_ready_i = 1'b0;

        // Randomized fetches against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pc;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) pc = $urandom | 32'h100;
            else if (sel < 4 && tag_valid_m) pc = tag_pc_m;
            else pc = 32'($urandom_range(0, 255));
            fetch(pc, $urandom_range(0, 4),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                  ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) pulse_dispatch();
            if ($urandom_range(0, 3) == 0) begin
                mem_read_ready_i = 1'b1;
                mem_read_data_i = 16'($urandom);
                step();
                mem_read_ready_i = 1'b0;
                chk("rnd_idle_state", fetcher_state_o, FETCH_IDLE);
                chk("rnd_idle_instr", instruction_out_o, instr_m);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
